// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter/sequencer sharing one ALU32 among 8 requesters.
// Optional back-to-back lock hold is enabled by defining ALU_ARB_LOCK_EN.
module alu_rr_arbiter #(
    parameter int unsigned ALU_LAT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic [7:0] lock,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       alu_start,
    output logic [7:0] ack,
    output logic       busy
);

    typedef enum logic [1:0] {StIdle, StBusy, StAck} state_e;

    localparam logic [3:0] CntLoad = 4'(ALU_LAT - 1);

    state_e     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] gnt_q, gnt_d;
    logic [7:0] ack_q, ack_d;
    logic       start_q, start_d;
    logic       busy_q, busy_d;

    logic [2:0] win;
    logic       found;
    logic       relock;

`ifdef ALU_ARB_LOCK_EN
    assign relock = lock[idx_q] & req[idx_q];
`else
    logic unused_lock;
    assign relock      = 1'b0;
    assign unused_lock = ^lock;
`endif

    // Scan from ptr upward, wrapping through the 3-bit index.
    always_comb begin
        win   = ptr_q;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!found && req[ptr_q + 3'(i)]) begin
                win   = ptr_q + 3'(i);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        ack_d   = 8'd0;
        start_d = 1'b0;
        busy_d  = busy_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    state_d = StBusy;
                    idx_d   = win;
                    gnt_d   = 8'd1 << win;
                    start_d = 1'b1;
                    cnt_d   = CntLoad;
                    busy_d  = 1'b1;
                end
            end
            StBusy: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = StAck;
                    ack_d   = gnt_q;
                    ptr_d   = idx_q + 3'd1;
                end
            end
            StAck: begin
                if (relock) begin
                    state_d = StBusy;
                    start_d = 1'b1;
                    cnt_d   = CntLoad;
                end else begin
                    state_d = StIdle;
                    gnt_d   = 8'd0;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= 3'd0;
            idx_q   <= 3'd0;
            cnt_q   <= 4'd0;
            gnt_q   <= 8'd0;
            ack_q   <= 8'd0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            start_q <= start_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign alu_start = start_q;
    assign ack       = ack_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Self-checking bench for alu_rr_arbiter (ALU_LAT=2 main instance, ALU_LAT=1 second instance).
// Expectations follow ALU_ARB_LOCK_EN the same way the design does.
module tb_alu_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst, rst1;
    logic [7:0] req, lock, req1, lock1;
    logic [7:0] gnt, ack, gnt1, ack1;
    logic [2:0] gnt_idx, gnt_idx1;
    logic       alu_start, busy, alu_start1, busy1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_rr_arbiter #(.ALU_LAT(2)) u_dut (
        .clk(clk), .rst(rst), .req(req), .lock(lock), .gnt(gnt), .gnt_idx(gnt_idx),
        .alu_start(alu_start), .ack(ack), .busy(busy)
    );

    alu_rr_arbiter #(.ALU_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst1), .req(req1), .lock(lock1), .gnt(gnt1), .gnt_idx(gnt_idx1),
        .alu_start(alu_start1), .ack(ack1), .busy(busy1)
    );

    // Advance one cycle; outputs are stable and inputs are driven 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        req  = 8'hFF;
        lock = 8'h00;
        tick();
        tick();
        checks++;
        if ({gnt, gnt_idx} !== 11'd0) begin
            failures++;
            $display("FAIL reset_gnt: got gnt=%h idx=%0d, want 0/0", gnt, gnt_idx);
        end
        checks++;
        if ({alu_start, ack, busy} !== 10'd0) begin
            failures++;
            $display("FAIL reset_ctrl: got start=%b ack=%h busy=%b, want 0", alu_start, ack, busy);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (gnt_idx !== 3'd0 || gnt !== 8'h01 || alu_start !== 1'b1) begin
            failures++;
            $display("FAIL reset_first_grant: got idx=%0d gnt=%h start=%b, want 0/01/1",
                     gnt_idx, gnt, alu_start);
        end
        tick();
        tick();
        req = 8'h00;
        tick();
    endtask

    task automatic test_single();
        req = 8'h10;
        tick();
        checks++;
        if (gnt !== 8'h10 || gnt_idx !== 3'd4 || alu_start !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_c1: got gnt=%h idx=%0d start=%b busy=%b, want 10/4/1/1",
                     gnt, gnt_idx, alu_start, busy);
        end
        tick();
        checks++;
        if (alu_start !== 1'b0 || ack !== 8'h00 || gnt !== 8'h10) begin
            failures++;
            $display("FAIL single_c2: got start=%b ack=%h gnt=%h, want 0/00/10", alu_start, ack, gnt);
        end
        tick();
        checks++;
        if (ack !== 8'h10 || gnt !== 8'h10 || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_c3: got ack=%h gnt=%h busy=%b, want 10/10/1", ack, gnt, busy);
        end
        req = 8'h00;
        tick();
        checks++;
        if (busy !== 1'b0 || gnt !== 8'h00 || ack !== 8'h00) begin
            failures++;
            $display("FAIL single_c4: got busy=%b gnt=%h ack=%h, want 0/00/00", busy, gnt, ack);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] seq [7] = '{8'h81, 8'h81, 8'h81, 8'h81, 8'h40, 8'h81, 8'h81};
        int         exp [7] = '{0, 7, 0, 7, 6, 7, 0};
        do_reset();
        for (int k = 0; k < 7; k++) begin
            req = seq[k];
            tick();
            checks++;
            if (gnt_idx !== 3'(exp[k]) || gnt !== (8'd1 << exp[k])) begin
                failures++;
                $display("FAIL rr_grant[%0d]: got idx=%0d gnt=%h, want idx=%0d", k, gnt_idx, gnt,
                         exp[k]);
            end
            tick();
            tick();
            checks++;
            if (ack !== (8'd1 << exp[k])) begin
                failures++;
                $display("FAIL rr_ack[%0d]: got %h, want %h", k, ack, 8'd1 << exp[k]);
            end
            tick();
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_reset_mid();
        logic [7:0] ack_seen = 8'h00;
        req = 8'h08;
        tick();
        checks++;
        if (gnt !== 8'h08) begin
            failures++;
            $display("FAIL midrst_grant: got %h, want 08", gnt);
        end
        rst = 1'b1;
        req = 8'h00;
        tick();
        checks++;
        if (gnt !== 8'h00 || busy !== 1'b0 || ack !== 8'h00) begin
            failures++;
            $display("FAIL midrst_clear: got gnt=%h busy=%b ack=%h, want 0", gnt, busy, ack);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            ack_seen |= ack;
        end
        checks++;
        if (ack_seen !== 8'h00) begin
            failures++;
            $display("FAIL midrst_noack: got ack bits %h, want 00", ack_seen);
        end
        // Pointer was 1 before the reset; a winner of 0 shows it was cleared.
        req = 8'hFF;
        tick();
        checks++;
        if (gnt_idx !== 3'd0) begin
            failures++;
            $display("FAIL midrst_ptr: got idx=%0d, want 0", gnt_idx);
        end
        tick();
        tick();
        req = 8'h00;
        tick();
    endtask

    task automatic test_latency();
        rst1 = 1'b1;
        tick();
        rst1 = 1'b0;
        req1 = 8'h02;
        tick();
        checks++;
        if (alu_start1 !== 1'b1 || gnt1 !== 8'h02 || ack1 !== 8'h00) begin
            failures++;
            $display("FAIL lat1_c1: got start=%b gnt=%h ack=%h, want 1/02/00", alu_start1, gnt1,
                     ack1);
        end
        tick();
        checks++;
        if (ack1 !== 8'h02 || alu_start1 !== 1'b0) begin
            failures++;
            $display("FAIL lat1_c2: got ack=%h start=%b, want 02/0", ack1, alu_start1);
        end
        req1 = 8'h00;
        tick();
        checks++;
        if (busy1 !== 1'b0) begin
            failures++;
            $display("FAIL lat1_c3: got busy=%b, want 0", busy1);
        end
    endtask

    task automatic test_lock();
        do_reset();
        req  = 8'h06;
        lock = 8'h02;
        tick();
        checks++;
        if (gnt !== 8'h02 || alu_start !== 1'b1) begin
            failures++;
            $display("FAIL lock_first: got gnt=%h start=%b, want 02/1", gnt, alu_start);
        end
        tick();
        tick();
        checks++;
        if (ack !== 8'h02) begin
            failures++;
            $display("FAIL lock_ack1: got %h, want 02", ack);
        end
        tick();
`ifdef ALU_ARB_LOCK_EN
        lock = 8'h00;
        checks++;
        if (gnt !== 8'h02 || alu_start !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL lock_again: got gnt=%h start=%b busy=%b, want 02/1/1", gnt, alu_start,
                     busy);
        end
        tick();
        tick();
        checks++;
        if (ack !== 8'h02 || gnt !== 8'h02) begin
            failures++;
            $display("FAIL lock_ack2: got ack=%h gnt=%h, want 02/02", ack, gnt);
        end
        tick();
        tick();
`else
        checks++;
        if (gnt !== 8'h00 || busy !== 1'b0 || alu_start !== 1'b0) begin
            failures++;
            $display("FAIL nolock_idle: got gnt=%h busy=%b start=%b, want 0", gnt, busy, alu_start);
        end
        tick();
`endif
        checks++;
        if (gnt_idx !== 3'd2 || gnt !== 8'h04 || alu_start !== 1'b1) begin
            failures++;
            $display("FAIL lock_next: got idx=%0d gnt=%h start=%b, want 2/04/1", gnt_idx, gnt,
                     alu_start);
        end
        tick();
        tick();
        req  = 8'h00;
        lock = 8'h00;
        tick();
    endtask

    task automatic test_random();
        logic [7:0] pending = 8'h00;
        int         ptr_m = 0;
        int         w;
        int         bad = 0;
        do_reset();
        for (int t = 0; t < 60; t++) begin
            pending |= 8'($urandom_range(0, 255));
            if (pending == 8'h00) pending = 8'd1 << $urandom_range(0, 7);
            req = pending;
            w = -1;
            for (int k = 0; k < 8; k++) begin
                if (w < 0 && pending[(ptr_m + k) % 8]) w = (ptr_m + k) % 8;
            end
            tick();
            checks++;
            if (gnt !== (8'd1 << w) || gnt_idx !== 3'(w) || alu_start !== 1'b1) begin
                failures++;
                $display("FAIL rand_grant[%0d]: got idx=%0d gnt=%h start=%b, want idx=%0d", t,
                         gnt_idx, gnt, alu_start, w);
            end
            if ($urandom_range(0, 2) == 0) begin
                pending[w] = 1'b0;
                req = pending;
            end
            tick();
            if (alu_start !== 1'b0 || ack !== 8'h00 || gnt !== (8'd1 << w)) bad++;
            tick();
            checks++;
            if (ack !== (8'd1 << w) || busy !== 1'b1) begin
                failures++;
                $display("FAIL rand_ack[%0d]: got ack=%h busy=%b, want %h/1", t, ack, busy,
                         8'd1 << w);
            end
            pending[w] = 1'b0;
            req = pending;
            ptr_m = (w + 1) % 8;
            tick();
            if (busy !== 1'b0 || gnt !== 8'h00 || ack !== 8'h00) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL rand_hold_idle: got %0d bad hold/idle cycles, want 0", bad);
        end
        req = 8'h00;
        tick();
    endtask

    initial begin
        rst   = 1'b1;
        rst1  = 1'b1;
        req   = 8'h00;
        lock  = 8'h00;
        req1  = 8'h00;
        lock1 = 8'h00;
        test_reset();
        test_single();
        test_round_robin();
        test_reset_mid();
        test_latency();
        test_lock();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
